// File: rtl/rf_trace_pkg.sv
// Shared definitions for the register-file write tracer.
package rf_trace_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // One trace entry is {cycle stamp, register index, data}.
  function automatic int entry_w(input int cyc_w, input int addr_w, input int data_w);
    return cyc_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular buffer of DEPTH entries with push, pop and optional overwrite-oldest.
module trace_ring #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 53
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    wrap,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok, do_write, overwrite, grow;

  // Pointer and occupancy update; an overwrite advances rd exactly once even with a pop.
  always_comb begin
    full      = (cnt_q == CNT_W'(DEPTH));
    pop_ok    = pop & (cnt_q != '0);
    overwrite = push & full & wrap;
    do_write  = push & (~full | wrap);
    grow      = do_write & ~full;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_write) wr_d = wr_q + 1'b1;
      if (pop_ok | overwrite) rd_d = rd_q + 1'b1;
      if (grow & ~pop_ok) cnt_d = cnt_q + 1'b1;
      else if (pop_ok & ~overwrite & ~grow) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_write & ~clear) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/rf_write_tracer.sv
// Records filtered register-file writes as {stamp, index, data} entries, drained via valid/ready.
module rf_write_tracer
  import rf_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rf_we,
  input  logic [ADDR_W-1:0]        rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     clear,
  input  logic                     wrap_mode,
  input  logic [2**ADDR_W-1:0]     watch_mask,
  input  logic [CYC_W-1:0]         cycle_limit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state_o
);

  localparam int ENTRY_W = entry_w(CYC_W, ADDR_W, DATA_W);

  logic [1:0]         state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               ovf_q, ovf_d;
  logic               run, capture, limit_hit, full, pop, arm_go;
  logic [ENTRY_W-1:0] din, dout;

  // Write filter: only watched, non-zero registers while running.
  always_comb begin
    run       = (state_q == S_RUN);
    capture   = run & rf_we & watch_mask[rf_waddr] & (rf_waddr != '0);
    limit_hit = run & (cycle_limit != '0) & (cyc_q == cycle_limit - 1'b1);
    pop       = out_valid & out_ready;
    din       = {cyc_q, rf_waddr, rf_wdata};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: clear beats stop, stop beats arm.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm & ~stop) state_d = S_RUN;
        S_RUN:   if (stop | limit_hit | (full & ~wrap_mode & capture)) state_d = S_DONE;
        S_DONE:  if (arm & ~stop) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    state_o   = state_q;
    out_valid = (count != '0);
    arm_go    = (state_d == S_RUN) & ~run;
  end

  // Cycle stamp and sticky overflow next-state.
  always_comb begin
    cyc_d = cyc_q;
    if (arm_go) cyc_d = '0;
    else if (run & (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
    ovf_d = ovf_q;
    if (clear) ovf_d = 1'b0;
    else if (capture & full) ovf_d = 1'b1;
  end

  // Cycle stamp and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
    end
  end

  trace_ring #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ring (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (capture),
    .pop   (pop),
    .wrap  (wrap_mode),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full)
  );

  assign {out_cycle, out_addr, out_data} = dout;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rf_write_tracer.sv
// Directed bench for rf_write_tracer with default parameters.
module tb_rf_write_tracer;

  logic        clk = 1'b0;
  logic        reset, rf_we, arm, stop, clear, wrap_mode, out_ready;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] watch_mask;
  logic [15:0] cycle_limit;
  logic        out_valid, overflow;
  logic [15:0] out_cycle;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic [1:0]  state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  rf_write_tracer dut (
    .clk(clk), .reset(reset), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .arm(arm), .stop(stop), .clear(clear), .wrap_mode(wrap_mode), .watch_mask(watch_mask),
    .cycle_limit(cycle_limit), .out_valid(out_valid), .out_ready(out_ready),
    .out_cycle(out_cycle), .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic write_rf(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (state_o !== 2'b00) $display("FAIL reset_state got %0d exp 0", state_o); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", overflow); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pulse_clear();
    pulse_arm();
    total_cnt++; if (state_o !== 2'b01) $display("FAIL basic_run got %0d exp 1", state_o); else pass_cnt++;
    tick(); tick();
    rf_we = 1'b1; rf_waddr = 5'd8; rf_wdata = 32'd5;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_pre got %0b exp 0", out_valid); else pass_cnt++;
    tick();
    rf_we = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %0b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (count !== 5'd1) $display("FAIL basic_count got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (out_cycle !== 16'd2) $display("FAIL basic_stamp got %0d exp 2", out_cycle); else pass_cnt++;
    total_cnt++; if (out_addr !== 5'd8) $display("FAIL basic_addr got %0d exp 8", out_addr); else pass_cnt++;
    total_cnt++; if (out_data !== 32'd5) $display("FAIL basic_data got %0d exp 5", out_data); else pass_cnt++;
    pulse_stop();
    total_cnt++; if (state_o !== 2'b10) $display("FAIL basic_done got %0d exp 2", state_o); else pass_cnt++;
    out_ready = 1'b1; tick();
    total_cnt++; if (count !== 5'd0) $display("FAIL basic_pop got %0d exp 0", count); else pass_cnt++;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (count !== 5'd0) $display("FAIL basic_pop_empty got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_filter();
    pulse_clear();
    watch_mask = 32'h0000_0200;
    pulse_arm();
    write_rf(5'd8, 32'd1);
    write_rf(5'd9, 32'd2);
    write_rf(5'd10, 32'd3);
    total_cnt++; if (count !== 5'd1) $display("FAIL filter_count got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (out_addr !== 5'd9) $display("FAIL filter_addr got %0d exp 9", out_addr); else pass_cnt++;
    total_cnt++; if (out_data !== 32'd2) $display("FAIL filter_data got %0d exp 2", out_data); else pass_cnt++;
    total_cnt++; if (out_cycle !== 16'd1) $display("FAIL filter_stamp got %0d exp 1", out_cycle); else pass_cnt++;
    watch_mask = 32'hFFFF_FFFF;
    pulse_stop();
    drain();
  endtask

  task automatic test_zero_reg();
    pulse_clear();
    pulse_arm();
    write_rf(5'd0, 32'd7);
    tick();
    total_cnt++; if (count !== 5'd0) $display("FAIL zero_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL zero_valid got %0b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_full_nowrap();
    pulse_clear();
    wrap_mode = 1'b0;
    pulse_arm();
    for (int i = 1; i <= 17; i++) write_rf(5'd8, 32'(i));
    total_cnt++; if (count !== 5'd16) $display("FAIL nowrap_count got %0d exp 16", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL nowrap_ovf got %0b exp 1", overflow); else pass_cnt++;
    total_cnt++; if (state_o !== 2'b10) $display("FAIL nowrap_state got %0d exp 2", state_o); else pass_cnt++;
    total_cnt++; if (out_data !== 32'd1) $display("FAIL nowrap_first got %0d exp 1", out_data); else pass_cnt++;
    total_cnt++; if (out_cycle !== 16'd0) $display("FAIL nowrap_stamp got %0d exp 0", out_cycle); else pass_cnt++;
    pulse_clear();
    total_cnt++; if (count !== 5'd0) $display("FAIL clear_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL clear_ovf got %0b exp 0", overflow); else pass_cnt++;
    total_cnt++; if (state_o !== 2'b00) $display("FAIL clear_state got %0d exp 0", state_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    pulse_clear();
    wrap_mode = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 20; i++) write_rf(5'd8, 32'(i));
    total_cnt++; if (count !== 5'd16) $display("FAIL wrap_count got %0d exp 16", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL wrap_ovf got %0b exp 1", overflow); else pass_cnt++;
    total_cnt++; if (state_o !== 2'b01) $display("FAIL wrap_state got %0d exp 1", state_o); else pass_cnt++;
    pulse_stop();
    for (int k = 5; k <= 20; k++) begin
      total_cnt++; if (out_data !== 32'(k)) $display("FAIL wrap_drain got %0d exp %0d", out_data, k); else pass_cnt++;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    total_cnt++; if (count !== 5'd0) $display("FAIL wrap_empty got %0d exp 0", count); else pass_cnt++;
    wrap_mode = 1'b0;
  endtask

  task automatic test_limit();
    pulse_clear();
    cycle_limit = 16'd10;
    pulse_arm();
    for (int i = 0; i < 12; i++) write_rf(5'd8, 32'(i));
    total_cnt++; if (state_o !== 2'b10) $display("FAIL limit_state got %0d exp 2", state_o); else pass_cnt++;
    total_cnt++; if (count !== 5'd10) $display("FAIL limit_count got %0d exp 10", count); else pass_cnt++;
    total_cnt++; if (out_cycle !== 16'd0) $display("FAIL limit_first got %0d exp 0", out_cycle); else pass_cnt++;
    out_ready = 1'b1; repeat (9) tick(); out_ready = 1'b0;
    total_cnt++; if (out_cycle !== 16'd9) $display("FAIL limit_last got %0d exp 9", out_cycle); else pass_cnt++;
    total_cnt++; if (out_data !== 32'd9) $display("FAIL limit_last_data got %0d exp 9", out_data); else pass_cnt++;
    cycle_limit = 16'd0;
    drain();
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    wrap_mode = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 16; i++) write_rf(5'd8, 32'(i));
    total_cnt++; if (out_data !== 32'd1) $display("FAIL b2b_pre got %0d exp 1", out_data); else pass_cnt++;
    out_ready = 1'b1;
    write_rf(5'd8, 32'd17);
    out_ready = 1'b0;
    total_cnt++; if (count !== 5'd16) $display("FAIL b2b_count got %0d exp 16", count); else pass_cnt++;
    pulse_stop();
    for (int k = 2; k <= 17; k++) begin
      total_cnt++; if (out_data !== 32'(k)) $display("FAIL b2b_drain got %0d exp %0d", out_data, k); else pass_cnt++;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty got %0b exp 0", out_valid); else pass_cnt++;
    wrap_mode = 1'b0;
  endtask

  task automatic test_priority();
    pulse_clear();
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    total_cnt++; if (state_o !== 2'b00) $display("FAIL prio_idle got %0d exp 0", state_o); else pass_cnt++;
    pulse_arm();
    pulse_stop();
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    total_cnt++; if (state_o !== 2'b10) $display("FAIL prio_done got %0d exp 2", state_o); else pass_cnt++;
    pulse_arm();
    write_rf(5'd3, 32'hA5);
    rf_we = 1'b1; rf_waddr = 5'd4; rf_wdata = 32'h5A; clear = 1'b1; arm = 1'b1; out_ready = 1'b1;
    tick();
    rf_we = 1'b0; clear = 1'b0; arm = 1'b0; out_ready = 1'b0;
    total_cnt++; if (count !== 5'd0) $display("FAIL prio_clear_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (state_o !== 2'b00) $display("FAIL prio_clear_state got %0d exp 0", state_o); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    pulse_clear();
    pulse_arm();
    write_rf(5'd8, 32'd1);
    write_rf(5'd9, 32'd2);
    write_rf(5'd10, 32'd3);
    total_cnt++; if (count !== 5'd3) $display("FAIL midrun_pre got %0d exp 3", count); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (count !== 5'd0) $display("FAIL midrun_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrun_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (state_o !== 2'b00) $display("FAIL midrun_state got %0d exp 0", state_o); else pass_cnt++;
    #1 reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    arm = 1'b0; stop = 1'b0; clear = 1'b0; wrap_mode = 1'b0; out_ready = 1'b0;
    watch_mask = 32'hFFFF_FFFF; cycle_limit = '0;
    test_reset();
    test_basic();
    test_filter();
    test_zero_reg();
    test_full_nowrap();
    test_wrap();
    test_limit();
    test_back_to_back();
    test_priority();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
